// File: rtl/strobe_byte_tx.sv
// Byte framer for the strobe-qualified serial link: start strobe, eight data strobes, stop strobe.
// Optional completed-frame counter (frame_count) enabled by defining STROBE_BYTE_TX_FRAMECNT_EN.
module strobe_byte_tx #(
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        strobe,
  output logic        sdata,
  output logic        active,
  output logic [2:0]  bitno,
  output logic        busy
`ifdef STROBE_BYTE_TX_FRAMECNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // DIV is expected in 2..255 so the divider fits in 8 bits.
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  state_t     state_reg;
  logic [7:0] div_reg;
  logic [7:0] shift_reg;
  logic [7:0] load_vec;
  logic       in_ready_reg;
  logic       strobe_reg;
  logic       sdata_reg;
  logic       active_reg;
  logic [2:0] bitno_reg;
  logic       fire;

  // Bit order is resolved at load time so the shifter always emits bit 0 next.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_load
      if (MSB_FIRST) begin : g_rev
        assign load_vec[gi] = in_data[7 - gi];
      end else begin : g_fwd
        assign load_vec[gi] = in_data[gi];
      end
    end
  endgenerate

  assign fire = (div_reg == DIV_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      shift_reg    <= '0;
      in_ready_reg <= 1'b1;
      strobe_reg   <= 1'b0;
      sdata_reg    <= 1'b0;
      active_reg   <= 1'b0;
      bitno_reg    <= '0;
    end else begin
      strobe_reg <= 1'b0;
      if (state_reg != IDLE) begin
        div_reg <= fire ? 8'd0 : div_reg + 8'd1;
      end
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg    <= load_vec;
            div_reg      <= '0;
            state_reg    <= START;
            in_ready_reg <= 1'b0;
            active_reg   <= 1'b1;
          end
        end
        START: begin
          if (fire) begin
            strobe_reg <= 1'b1;
            sdata_reg  <= 1'b0;
            state_reg  <= DATA;
          end
        end
        DATA: begin
          if (fire) begin
            strobe_reg <= 1'b1;
            sdata_reg  <= shift_reg[0];
            shift_reg  <= {1'b0, shift_reg[7:1]};
            bitno_reg  <= bitno_reg + 3'd1;
            // Eighth data strobe: bitno wraps to 0 on this same edge.
            if (bitno_reg == 3'd7) begin
              state_reg  <= STOP;
              active_reg <= 1'b0;
            end
          end
        end
        STOP: begin
          if (fire) begin
            strobe_reg   <= 1'b1;
            sdata_reg    <= 1'b0;
            state_reg    <= IDLE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_reg;
  assign busy     = ~in_ready_reg;
  assign strobe   = strobe_reg;
  assign sdata    = sdata_reg;
  assign active   = active_reg;
  assign bitno    = bitno_reg;

`ifdef STROBE_BYTE_TX_FRAMECNT_EN
  logic [15:0] frame_count_reg;

  // Counts stop strobes only, so a frame aborted by reset is never counted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_count_reg <= '0;
    end else if ((state_reg == STOP) && fire) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_strobe_byte_tx.sv
// Bench for strobe_byte_tx: two instances (DIV=4 LSB-first, DIV=2 MSB-first) checked every cycle
// against a timing-arithmetic model, plus table-driven frames and hand-written corner sequences.
module tb_strobe_byte_tx;

  localparam int DIV_A = 4;
  localparam int DIV_B = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       in_valid [2];
  logic [7:0] in_data  [2];
  logic       in_ready [2];
  logic       strobe   [2];
  logic       sdata    [2];
  logic       active   [2];
  logic       busy     [2];
  logic [2:0] bitno    [2];
`ifdef STROBE_BYTE_TX_FRAMECNT_EN
  logic [15:0] frame_count [2];
`endif

  always #5 sys_clk = ~sys_clk;

  strobe_byte_tx #(.DIV(DIV_A), .MSB_FIRST(1'b0)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .strobe(strobe[0]), .sdata(sdata[0]), .active(active[0]),
    .bitno(bitno[0]), .busy(busy[0])
`ifdef STROBE_BYTE_TX_FRAMECNT_EN
    , .frame_count(frame_count[0])
`endif
  );

  strobe_byte_tx #(.DIV(DIV_B), .MSB_FIRST(1'b1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .strobe(strobe[1]), .sdata(sdata[1]), .active(active[1]),
    .bitno(bitno[1]), .busy(busy[1])
`ifdef STROBE_BYTE_TX_FRAMECNT_EN
    , .frame_count(frame_count[1])
`endif
  );

  // Reference model state: when the current frame was accepted and what byte it carries.
  bit         has_f  [2];
  int         t_acc  [2];
  logic [7:0] byte_m [2];
  int         fc_m   [2];
  int         ecount;
  bit         fc_load;
  int         n_checks;
  int         n_fail;

  function automatic int div_of(int i);
    return (i == 0) ? DIV_A : DIV_B;
  endfunction

  // Expected {in_ready, busy, strobe, sdata, active, bitno} from the cycle offset since accept.
  function automatic logic [7:0] model_out(int div, bit msb, bit has, int off, logic [7:0] b);
    int j;
    logic r, bz, st, sd, ac;
    logic [2:0] bn;
    r = 1'b1; bz = 1'b0; st = 1'b0; sd = 1'b0; ac = 1'b0; bn = 3'd0;
    if (has && off < 10 * div) begin
      j  = off / div;
      r  = 1'b0;
      bz = 1'b1;
      st = ((off % div) == 0) && (j >= 1);
      ac = (j < 9);
      if (j >= 2 && j <= 8) bn = 3'(j - 1);
      if (j >= 2 && j <= 9) sd = msb ? b[9 - j] : b[j - 2];
    end else if (has && off == 10 * div) begin
      st = 1'b1;
    end
    return {r, bz, st, sd, ac, bn};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pos_half();
    int off;
    @(posedge sys_clk);
    ecount++;
    for (int i = 0; i < 2; i++) begin
      if (!sys_rst_n) begin
        has_f[i] = 1'b0;
        fc_m[i]  = 0;
      end else begin
        off = ecount - t_acc[i];
        if ((!has_f[i] || off > 10 * div_of(i)) && in_valid[i]) begin
          has_f[i]  = 1'b1;
          t_acc[i]  = ecount;
          byte_m[i] = in_data[i];
        end else if (has_f[i] && off == 10 * div_of(i)) begin
          fc_m[i] = (fc_m[i] + 1) & 16'hFFFF;
        end
        if (fc_load && i == 0) fc_m[i] = 16'hFFFF;
      end
    end
  endtask

  task automatic neg_half();
    logic [7:0] exp_v;
    logic [7:0] act_v;
    @(negedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      if (!sys_rst_n) exp_v = 8'h80;
      else exp_v = model_out(div_of(i), (i == 1), has_f[i], ecount - t_acc[i], byte_m[i]);
      act_v = {in_ready[i], busy[i], strobe[i], sdata[i], active[i], bitno[i]};
      check($sformatf("mon_dut%0d cyc%0d {rdy,busy,stb,sd,act,bitno}", i, ecount), 32'(act_v), 32'(exp_v));
`ifdef STROBE_BYTE_TX_FRAMECNT_EN
      check($sformatf("mon_dut%0d frame_count", i), 32'(frame_count[i]),
            sys_rst_n ? 32'(fc_m[i]) : 32'd0);
`endif
    end
  endtask

  task automatic tick();
    pos_half();
    neg_half();
  endtask

  // Waits (bounded) for an accept, then records every strobe up to two cycles past the frame.
  task automatic send_frame(int i, logic [7:0] b, output logic [9:0] seq,
                            output int first, output int last, output int n, output int rdy);
    bit accepted;
    accepted = 1'b0;
    in_valid[i] = 1'b1;
    in_data[i]  = b;
    for (int k = 0; k < 200 && !accepted; k++) begin
      accepted = in_ready[i];
      tick();
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    in_valid[i] = 1'b0;
    in_data[i]  = 8'($urandom);
    seq = '0; first = -1; last = -1; n = 0; rdy = -1;
    for (int off = 0; off <= 10 * div_of(i) + 2; off++) begin
      if (off > 0) tick();
      if (strobe[i]) begin
        seq = {seq[8:0], sdata[i]};
        n++;
        if (first < 0) first = off;
        last = off;
      end
      if (in_ready[i] && rdy < 0) rdy = off;
    end
  endtask

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [9:0] seq;
  } vec_t;

  vec_t       vecs [6];
  logic [9:0] seq;
  int         first, last, n, rdy;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Symbols in send order: start, 8 data bits, stop (first symbol in bit 9).
    vecs[0] = '{dut: 0, data: 8'hA5, seq: 10'b0101001010};
    vecs[1] = '{dut: 1, data: 8'h81, seq: 10'b0100000010};
    vecs[2] = '{dut: 0, data: 8'h12, seq: 10'b0010010000};
    vecs[3] = '{dut: 1, data: 8'h12, seq: 10'b0000100100};
    vecs[4] = '{dut: 0, data: 8'hFF, seq: 10'b0111111110};
    vecs[5] = '{dut: 1, data: 8'h3C, seq: 10'b0001111000};

    n_checks = 0; n_fail = 0; ecount = 0; fc_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = 8'h00;
      has_f[i] = 1'b0; t_acc[i] = 0; byte_m[i] = 8'h00; fc_m[i] = 0;
    end
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b1;

    // Idle for 50 cycles: no strobes at all.
    n = 0;
    repeat (50) begin
      tick();
      if (strobe[0] || strobe[1]) n++;
    end
    check("idle_no_strobe", 32'(n), 32'd0);
    check("idle_state_a", {29'd0, in_ready[0], active[0], 1'b0} | 32'(bitno[0]), 32'h4);

    // Table-driven frames on both divider settings.
    foreach (vecs[v]) begin
      send_frame(vecs[v].dut, vecs[v].data, seq, first, last, n, rdy);
      $display("frame dut%0d data=0x%02h seq=%b first=%0d last=%0d n=%0d rdy=%0d",
               vecs[v].dut, vecs[v].data, seq, first, last, n, rdy);
      check($sformatf("vec%0d_seq", v), 32'(seq), 32'(vecs[v].seq));
      check($sformatf("vec%0d_count", v), 32'(n), 32'd10);
      check($sformatf("vec%0d_first", v), 32'(first), 32'(div_of(vecs[v].dut)));
      check($sformatf("vec%0d_last", v), 32'(last), 32'(10 * div_of(vecs[v].dut)));
      check($sformatf("vec%0d_ready", v), 32'(rdy), 32'(10 * div_of(vecs[v].dut)));
    end

    // Back-to-back: in_valid held high, 0x00 then 0xFF.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h00;
    while (!in_ready[0]) tick();
    tick();
    in_data[0] = 8'hFF;
    rdy = -1;
    for (int off = 0; off <= 12 * DIV_A && rdy < 0; off++) begin
      if (in_ready[0]) rdy = off;
      else tick();
    end
    check("b2b_stop_with_ready", 32'(strobe[0]), 32'd1);
    check("b2b_ready_offset", 32'(rdy), 32'(10 * DIV_A));
    tick();
    check("b2b_second_accept", 32'(in_ready[0]), 32'd0);
    in_valid[0] = 1'b0;
    seq = '0; n = 0;
    for (int off = 0; off <= 10 * DIV_A + 1; off++) begin
      if (off > 0) tick();
      if (strobe[0]) begin seq = {seq[8:0], sdata[0]}; n++; end
    end
    $display("back-to-back second frame seq=%b n=%0d", seq, n);
    check("b2b_second_seq", 32'(seq), 32'(10'b0111111110));
    check("b2b_second_count", 32'(n), 32'd10);

    // Reset during data strobe 4 aborts asynchronously.
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h5A;
    while (!in_ready[0]) tick();
    tick();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 12 * DIV_A && !(strobe[0] && bitno[0] == 3'd4); k++) tick();
    check("abort_at_strobe4", 32'(strobe[0] && bitno[0] == 3'd4), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1 check("abort_async_reset",
             32'({in_ready[0], busy[0], strobe[0], sdata[0], active[0], bitno[0]}), 32'h80);
    $display("reset mid-frame: outputs after async reset rdy=%0b stb=%0b bitno=%0d",
             in_ready[0], strobe[0], bitno[0]);
    tick();
    tick();
    sys_rst_n = 1'b1;
    send_frame(0, 8'h3C, seq, first, last, n, rdy);
    $display("post-reset frame data=0x3c seq=%b first=%0d n=%0d", seq, first, n);
    check("post_reset_seq", 32'(seq), 32'(10'b0001111000));
    check("post_reset_first", 32'(first), 32'(DIV_A));
    check("post_reset_count", 32'(n), 32'd10);

    // Random traffic on both instances, checked each cycle by the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 2) == 0);
        in_data[i]  = 8'($urandom);
      end
      tick();
    end
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    repeat (12 * DIV_A) tick();

`ifdef STROBE_BYTE_TX_FRAMECNT_EN
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    repeat (3) send_frame(0, 8'($urandom), seq, first, last, n, rdy);
    $display("frame counter after 3 frames = %0d", frame_count[0]);
    check("fc_three", 32'(frame_count[0]), 32'd3);
    #1;
    fc_load = 1'b1;
    force dut_a.frame_count_reg = 16'hFFFF;
    tick();
    #1;
    release dut_a.frame_count_reg;
    fc_load = 1'b0;
    send_frame(0, 8'h00, seq, first, last, n, rdy);
    $display("frame counter after wrap = 0x%04h", frame_count[0]);
    check("fc_wrap", 32'(frame_count[0]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
